// File: rtl/conv_encoder_punct.sv
// conv_encoder_punct: rate-1/2 K=7 convolutional encoder (g0=133o, g1=171o) with valid/ready on both sides.
// Define CONV_PUNCTURE_EN to enable 2/3 and 3/4 puncturing; otherwise every input emits A then B.
module conv_encoder_punct #(
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             reset,
  input  logic             frame_start,
  input  logic [1:0]       punct_mode,
  input  logic             in_bit,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out_bit,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] coded_cnt
);
  logic [5:0] s_q, s_d, s_eff;
  logic [1:0] buf_q, buf_d, pend_q, pend_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic pop, acc, a, b, keep_a, keep_b;
`ifdef CONV_PUNCTURE_EN
  logic [1:0] phase_q, phase_d, mode_q, mode_d, mode_eff, phase_eff, phase_max;
  always_comb begin
    mode_eff = frame_start ? punct_mode : mode_q;
    phase_eff = frame_start ? 2'd0 : phase_q;
    phase_max = mode_eff == 2'd1 ? 2'd1 : mode_eff == 2'd2 ? 2'd2 : 2'd0;
    keep_a = phase_eff != 2'd2;
    keep_b = phase_eff == 2'd0;
    mode_d = mode_eff;
    phase_d = !acc ? phase_eff : phase_eff >= phase_max ? 2'd0 : phase_eff + 2'd1;
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      phase_q <= 2'd0;
      mode_q <= 2'd0;
    end else begin
      phase_q <= phase_d;
      mode_q <= mode_d;
    end
  end
`else
  logic unused_mode;
  assign unused_mode = ^punct_mode;
  assign keep_a = 1'b1;
  assign keep_b = 1'b1;
`endif
  // An accept always lands in an empty buffer: in_ready only rises once the last bit drains.
  always_comb begin
    in_ready = frame_start || pend_q == 2'd0 || (pend_q == 2'd1 && out_ready);
    out_valid = pend_q != 2'd0;
    out_bit = buf_q[0];
    coded_cnt = cnt_q;
    acc = in_valid && in_ready;
    pop = out_valid && out_ready && !frame_start;
    s_eff = frame_start ? 6'd0 : s_q;
    a = in_bit ^ s_eff[1] ^ s_eff[2] ^ s_eff[4] ^ s_eff[5];
    b = in_bit ^ s_eff[0] ^ s_eff[1] ^ s_eff[2] ^ s_eff[5];
    s_d = acc ? {s_eff[4:0], in_bit} : s_eff;
    buf_d = acc ? (keep_a ? {b, a} : {1'b0, b}) : pop ? {1'b0, buf_q[1]} : buf_q;
    pend_d = acc ? (keep_a && keep_b ? 2'd2 : 2'd1) : frame_start ? 2'd0 : pend_q - {1'b0, pop};
    cnt_d = frame_start ? '0 : cnt_q + CNT_W'(pop);
  end
  always_ff @(posedge Clk) begin
    if (reset) begin
      s_q <= 6'd0;
      buf_q <= 2'd0;
      pend_q <= 2'd0;
      cnt_q <= '0;
    end else begin
      s_q <= s_d;
      buf_q <= buf_d;
      pend_q <= pend_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_conv_encoder_punct.sv
// tb_conv_encoder_punct: random and directed stimulus against a generator-polynomial reference model.
module tb_conv_encoder_punct;
  logic clk = 1'b0;
  logic reset = 1'b0, frame_start = 1'b0, in_bit = 1'b0, in_valid = 1'b0, out_ready = 1'b0;
  logic [1:0] punct_mode = 2'd0;
  logic in_ready, out_bit, out_valid;
  logic [15:0] coded_cnt;
  int checks = 0, failures = 0;
  bit mq[$];
  logic [6:0] mh = 7'd0;
  int midx = 0, mcnt = 0;
  logic [1:0] mmode = 2'd0;
  bit live = 0;
  logic [31:0] got_v = 32'd0;
  int got_n = 0;
  logic acc;

  always #5 clk = ~clk;

  conv_encoder_punct #(.CNT_W(16)) dut (
    .Clk(clk), .reset(reset), .frame_start(frame_start), .punct_mode(punct_mode),
    .in_bit(in_bit), .in_valid(in_valid), .in_ready(in_ready), .out_bit(out_bit),
    .out_valid(out_valid), .out_ready(out_ready), .coded_cnt(coded_cnt)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Octal generator: MSB taps the current input, LSB taps the bit six inputs back.
  function automatic bit gen(input logic [6:0] w, input logic [6:0] g);
    bit r = 0;
    for (int d = 0; d < 7; d++) if (g[6-d]) r ^= w[d];
    return r;
  endfunction

  task automatic cycle(input logic fs, input logic [1:0] pm, input logic iv, input logic ib,
                       input logic ordy, input logic rst, output logic acc_o);
    logic erdy;
    logic [6:0] w;
    int per, ph;
    bit a, b;
    @(negedge clk);
    frame_start = fs; punct_mode = pm; in_valid = iv; in_bit = ib; out_ready = ordy; reset = rst;
    #1;
    erdy = fs || mq.size() == 0 || (mq.size() == 1 && ordy);
    if (live) begin
      check("out_valid", out_valid, mq.size() != 0);
      if (mq.size() != 0) check("out_bit", out_bit, mq[0]);
      check("in_ready", in_ready, erdy);
      check("coded_cnt", coded_cnt, mcnt);
    end
    if (out_valid && ordy && !fs && !rst) begin
      got_v = {got_v[30:0], out_bit};
      got_n++;
    end
    acc_o = 1'b0;
    if (rst) begin
      mq.delete(); mh = 7'd0; midx = 0; mcnt = 0; mmode = 2'd0; live = 1;
    end else begin
      if (mq.size() != 0 && ordy && !fs) begin
        void'(mq.pop_front());
        mcnt = (mcnt + 1) % 65536;
      end
      if (fs) begin
        mq.delete(); mh = 7'd0; midx = 0; mcnt = 0;
`ifdef CONV_PUNCTURE_EN
        mmode = pm;
`else
        mmode = 2'd0;
`endif
      end
      acc_o = iv && erdy;
      if (acc_o) begin
        w = {mh[5:0], ib};
        a = gen(w, 7'o133);
        b = gen(w, 7'o171);
        per = mmode == 2'd1 ? 2 : mmode == 2'd2 ? 3 : 1;
        ph = midx % per;
        if (ph != 2) mq.push_back(a);
        if (ph != 1) mq.push_back(b);
        mh = w;
        midx++;
      end
    end
  endtask

  task automatic run_frame(input logic [1:0] pm, input logic [31:0] bits, input int n);
    int i = 0, g = 0;
    logic ac;
    got_v = 32'd0; got_n = 0;
    while (i < n && g < 100) begin
      cycle(i == 0 && g == 0, pm, 1'b1, bits[i], 1'b1, 1'b0, ac);
      if (ac) i++;
      g++;
    end
    for (int k = 0; k < 8 && mq.size() != 0; k++) cycle(1'b0, pm, 1'b0, 1'b0, 1'b1, 1'b0, ac);
    cycle(1'b0, pm, 1'b0, 1'b0, 1'b1, 1'b0, ac);
  endtask

  initial begin
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_bit", out_bit, 0);
    check("rst_cnt", coded_cnt, 0);
    check("rst_in_ready", in_ready, 1);

    run_frame(2'd0, 32'd1, 7);
    check("s1_stream", got_v, 32'b11011111001011);
    check("s1_len", got_n, 14);
    check("s1_cnt", coded_cnt, 14);

    run_frame(2'd2, 32'd1, 6);
`ifdef CONV_PUNCTURE_EN
    check("s2_stream", got_v, 32'b11011100);
    check("s2_len", got_n, 8);
    check("s2_cnt", coded_cnt, 8);
`else
    check("s2_stream", got_v, 32'b110111110010);
    check("s2_len", got_n, 12);
    check("s2_cnt", coded_cnt, 12);
`endif

    run_frame(2'd1, 32'd1, 4);
`ifdef CONV_PUNCTURE_EN
    check("s3_stream", got_v, 32'b110111);
    check("s3_cnt", coded_cnt, 6);
`else
    check("s3_stream", got_v, 32'b11011111);
    check("s3_cnt", coded_cnt, 8);
`endif

    got_v = 32'd0; got_n = 0;
    cycle(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    for (int k = 0; k < 5; k++) begin
      cycle(1'b0, 2'd0, 1'b1, 1'($urandom), 1'b0, 1'b0, acc);
      check("bp_valid", out_valid, 1);
      check("bp_bit", out_bit, 1);
      check("bp_in_ready", in_ready, 0);
    end
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check("bp_stream", got_v, 32'b11);
    check("bp_len", got_n, 2);
    check("bp_cnt", coded_cnt, 2);

    cycle(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b0, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    got_v = 32'd0; got_n = 0;
    cycle(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check("mf_cnt0", coded_cnt, 0);
    check("mf_bit0", out_bit, 1);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check("mf_cnt1", coded_cnt, 1);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check("mf_cnt2", coded_cnt, 2);
    check("mf_stream", got_v, 32'b11);

    cycle(1'b1, 2'd0, 1'b1, 1'b1, 1'b1, 1'b0, acc);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, acc);
    check("rm_pre_valid", out_valid, 1);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, acc);
    cycle(1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, acc);
    check("rm_out_valid", out_valid, 0);
    check("rm_in_ready", in_ready, 1);
    check("rm_cnt", coded_cnt, 0);
    run_frame(2'd0, 32'd1, 7);
    check("rm_stream", got_v, 32'b11011111001011);
    check("rm_cnt_after", coded_cnt, 14);

    for (int k = 0; k < 3000; k++)
      cycle($urandom_range(99) < 3, 2'($urandom), $urandom_range(99) < 80, 1'($urandom),
            $urandom_range(99) < 70, $urandom_range(199) == 0, acc);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
